// File: rtl/pht_update_queue_pkg.sv
// Shared predictor definitions for the PHT update path.
// Widths here are the predictor defaults; the queue block re-derives its own
// constants from its parameters so it can be built at other table sizes.
package pht_update_queue_pkg;

  localparam int PHT_INDEX_WIDTH_DEF = 10;
  localparam int PHT_ENTRY_WIDTH_DEF = 2;

  typedef logic [PHT_INDEX_WIDTH_DEF-1:0] PHT_IndexPath;
  typedef logic [PHT_ENTRY_WIDTH_DEF-1:0] PHT_EntryPath;

  // Saturation ceiling of a 2-bit counter.
  localparam PHT_EntryPath PHT_ENTRY_MAX = '1;
  // Weakly-taken: the MSB alone set.
  localparam PHT_EntryPath PHT_WEAK_TAKEN = PHT_EntryPath'(1 << (PHT_ENTRY_WIDTH_DEF-1));

  // One pending table write.
  typedef struct packed {
    PHT_IndexPath index;
    PHT_EntryPath value;
  } pht_queue_entry_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } pht_uq_state_e;

endpackage

// File: rtl/pht_update_fifo.sv
// Circular buffer for pending PHT writes: multi-lane write by explicit slot,
// single pop from the head. Slot choice (allocate vs. overwrite) is made by
// the caller; this block only moves pointers and holds the data.
module pht_update_fifo #(
  parameter int DEPTH = 8,
  parameter int LANES = 2,
  parameter int DW    = 12,
  parameter int IW    = 10
)(
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [LANES-1:0]                       wr_en,
  input  logic [LANES-1:0][$clog2(DEPTH)-1:0]    wr_addr,
  input  logic [LANES-1:0][DW-1:0]               wr_data,
  input  logic [$clog2(DEPTH):0]                 push_cnt,
  input  logic                                   pop,
  output logic [DW-1:0]                          head_data,
  output logic [IW-1:0]                          tail_index,
  output logic [$clog2(DEPTH)-1:0]               tail,
  output logic [$clog2(DEPTH):0]                 occ
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail_m1;
  logic [DW-1:0] tail_data;

  // Storage writes; later lanes win when two lanes target one slot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      if (wr_en[i]) mem[wr_addr[i]] <= wr_data[i];
  end

  // Pointer and count update; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      head <= head + AW'(pop);
      tail <= tail + push_cnt[AW-1:0];
      occ  <= occ + push_cnt - (AW+1)'(pop);
    end
  end

  assign tail_m1    = tail - AW'(1);
  assign head_data  = mem[head];
  assign tail_data  = mem[tail_m1];
  assign tail_index = tail_data[DW-1 -: IW];

endmodule

// File: rtl/pht_update_queue.sv
// PHT update queue: computes saturating-counter updates for resolved branches,
// queues them and drains one write per cycle to the PHT port. After reset it
// sweeps the whole table to weakly-taken before accepting any update.
// Optional feature macro: PHT_UPDATE_COALESCE_EN -- a lane hitting the index of
// the youngest queued entry (not the one popping this cycle) overwrites it.
module pht_update_queue
  import pht_update_queue_pkg::*;
#(
  parameter int IN_WIDTH        = 2,
  parameter int PHT_INDEX_WIDTH = PHT_INDEX_WIDTH_DEF,
  parameter int PHT_ENTRY_WIDTH = PHT_ENTRY_WIDTH_DEF,
  parameter int QUEUE_DEPTH     = 8
)(
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [IN_WIDTH-1:0]                            brValid,
  input  logic [IN_WIDTH-1:0][PHT_INDEX_WIDTH-1:0]       brIndex,
  input  logic [IN_WIDTH-1:0][PHT_ENTRY_WIDTH-1:0]       brPrevValue,
  input  logic [IN_WIDTH-1:0]                            brTaken,
  output logic                                           phtWE,
  output logic [PHT_INDEX_WIDTH-1:0]                     phtWA,
  output logic [PHT_ENTRY_WIDTH-1:0]                     phtWV,
  output logic                                           initDone,
  output logic [$clog2(QUEUE_DEPTH):0]                   occupancy,
  output logic [15:0]                                    dropCount
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int XW = PHT_INDEX_WIDTH;
  localparam int EW = PHT_ENTRY_WIDTH;
  localparam int DW = XW + EW;
  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam logic [EW-1:0] CNT_MAX  = '1;
  localparam logic [EW-1:0] CNT_WEAK = EW'(1) << (EW - 1);
`ifdef PHT_UPDATE_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  pht_uq_state_e state, state_nxt;
  logic [XW-1:0] sweep;

  logic [IN_WIDTH-1:0][EW-1:0]  new_val;
  logic [IN_WIDTH-1:0]          wr_en;
  logic [IN_WIDTH-1:0][AW-1:0]  wr_addr;
  logic [IN_WIDTH-1:0][DW-1:0]  wr_data;
  logic [AW:0]                  push_cnt;
  logic                         pop;
  logic [DW-1:0]                head_data;
  logic [XW-1:0]                tail_index;
  logic [AW-1:0]                fifo_tail;
  logic [AW:0]                  fifo_occ;
  logic [AW:0]                  avail;
  logic                         last_v;
  logic [XW-1:0]                last_idx;
  logic [AW-1:0]                last_addr;
  logic [CW-1:0]                drops;
  logic [16:0]                  drop_sum;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_INIT;
    else      state <= state_nxt;
  end

  // Leave INIT once the all-ones index has been written.
  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && (&sweep)) state_nxt = ST_RUN;
  end

  // Per-lane 2-bit saturating counter update.
  always_comb begin
    new_val = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (brTaken[i]) new_val[i] = (brPrevValue[i] == CNT_MAX) ? CNT_MAX : brPrevValue[i] + EW'(1);
      else            new_val[i] = (brPrevValue[i] == '0) ? '0 : brPrevValue[i] - EW'(1);
    end
  end

  // Lane allocation in lane order: coalesce into the youngest entry, else take
  // a free slot (counting the one vacated by this cycle's pop), else drop.
  always_comb begin
    wr_en     = '0;
    wr_addr   = '0;
    wr_data   = '0;
    push_cnt  = '0;
    drops     = '0;
    pop       = (state == ST_RUN) && (fifo_occ != '0);
    avail     = (AW+1)'(QUEUE_DEPTH) - fifo_occ + (AW+1)'(pop);
    // With one entry left it is the head being popped, so it cannot be a target.
    last_v    = COALESCE && (fifo_occ >= (AW+1)'(2));
    last_idx  = tail_index;
    last_addr = fifo_tail - AW'(1);
    for (int i = 0; i < IN_WIDTH; i++) begin
      wr_data[i] = {brIndex[i], new_val[i]};
      if (brValid[i]) begin
        if (state != ST_RUN) begin
          drops = drops + CW'(1);
        end else if (last_v && brIndex[i] == last_idx) begin
          wr_en[i]   = 1'b1;
          wr_addr[i] = last_addr;
        end else if (push_cnt < avail) begin
          wr_en[i]   = 1'b1;
          wr_addr[i] = fifo_tail + push_cnt[AW-1:0];
          push_cnt   = push_cnt + (AW+1)'(1);
          last_v     = COALESCE;
          last_idx   = brIndex[i];
          last_addr  = wr_addr[i];
        end else begin
          drops = drops + CW'(1);
        end
      end
    end
  end

  pht_update_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .LANES (IN_WIDTH),
    .DW    (DW),
    .IW    (XW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .push_cnt   (push_cnt),
    .pop        (pop),
    .head_data  (head_data),
    .tail_index (tail_index),
    .tail       (fifo_tail),
    .occ        (fifo_occ)
  );

  assign occupancy = fifo_occ;

  // Registered PHT write port: init sweep in INIT, queue head in RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phtWE    <= 1'b0;
      phtWA    <= '0;
      phtWV    <= '0;
      sweep    <= '0;
      initDone <= 1'b0;
    end else begin
      initDone <= (state == ST_RUN);
      if (state == ST_INIT) begin
        phtWE <= 1'b1;
        phtWA <= sweep;
        phtWV <= CNT_WEAK;
        sweep <= sweep + XW'(1);
      end else begin
        phtWE <= pop;
        if (pop) begin
          phtWA <= head_data[DW-1 -: XW];
          phtWV <= head_data[EW-1:0];
        end
      end
    end
  end

  assign drop_sum = {1'b0, dropCount} + 17'(drops);

  // Saturating count of discarded lanes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dropCount <= '0;
    else      dropCount <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

endmodule

// File: tb/tb_pht_update_queue.sv
// Self-checking bench for pht_update_queue (small 16-entry table).
// Reference model: an init counter plus a queue of {index,value} records.
module tb_pht_update_queue;
  localparam int L  = 2;
  localparam int XW = 4;
  localparam int EW = 2;
  localparam int D  = 8;
  localparam int NENT = 1 << XW;
  localparam int MAXV = (1 << EW) - 1;
`ifdef PHT_UPDATE_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [L-1:0]          brValid;
  logic [L-1:0][XW-1:0]  brIndex;
  logic [L-1:0][EW-1:0]  brPrevValue;
  logic [L-1:0]          brTaken;
  logic                  phtWE;
  logic [XW-1:0]         phtWA;
  logic [EW-1:0]         phtWV;
  logic                  initDone;
  logic [3:0]            occupancy;
  logic [15:0]           dropCount;

  pht_update_queue #(
    .IN_WIDTH(L), .PHT_INDEX_WIDTH(XW), .PHT_ENTRY_WIDTH(EW), .QUEUE_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst), .brValid(brValid), .brIndex(brIndex),
    .brPrevValue(brPrevValue), .brTaken(brTaken), .phtWE(phtWE),
    .phtWA(phtWA), .phtWV(phtWV), .initDone(initDone),
    .occupancy(occupancy), .dropCount(dropCount)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---- reference model ----
  typedef struct { int idx; int val; } ent_t;
  ent_t q[$];
  int  m_init, m_drop;
  bit  m_done, e_we;
  int  e_wa, e_wv;

  function automatic int upd(int p, bit t);
    if (t) return (p == MAXV) ? MAXV : p + 1;
    return (p == 0) ? 0 : p - 1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_init = 0; m_drop = 0; m_done = 0; e_we = 0; e_wa = 0; e_wv = 0;
  endtask

  // One rising edge, using the inputs presented during the cycle.
  task automatic model_step();
    e_we = 0;
    if (m_init < NENT) begin
      e_we = 1; e_wa = m_init; e_wv = 1 << (EW - 1);
      m_init++;
      for (int i = 0; i < L; i++) if (brValid[i]) m_drop++;
    end else begin
      m_done = 1;
      if (q.size() > 0) begin
        e_we = 1; e_wa = q[0].idx; e_wv = q[0].val;
        void'(q.pop_front());
      end
      for (int i = 0; i < L; i++) begin
        if (brValid[i]) begin
          int nv;
          ent_t e;
          nv = upd(int'(brPrevValue[i]), brTaken[i]);
          if (COAL && q.size() > 0 && q[q.size()-1].idx == int'(brIndex[i])) begin
            q[q.size()-1].val = nv;
          end else if (q.size() < D) begin
            e.idx = int'(brIndex[i]); e.val = nv;
            q.push_back(e);
          end else begin
            m_drop++;
          end
        end
      end
    end
    if (m_drop > 65535) m_drop = 65535;
  endtask

  task automatic check_all();
    chk("we", 32'(phtWE), 32'(e_we));
    if (e_we) begin
      chk("wa", 32'(phtWA), 32'(e_wa));
      chk("wv", 32'(phtWV), 32'(e_wv));
    end
    chk("initDone", 32'(initDone), 32'(m_done));
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    chk("dropCount", 32'(dropCount), 32'(m_drop));
  endtask

  task automatic cyc(input logic [1:0] v, input int i0, input int p0, input int t0,
                     input int i1, input int p1, input int t1);
    brValid        = v;
    brIndex[0]     = XW'(i0);  brIndex[1]     = XW'(i1);
    brPrevValue[0] = EW'(p0);  brPrevValue[1] = EW'(p1);
    brTaken[0]     = t0[0];    brTaken[1]     = t1[0];
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(2'b00, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rnd(input int n);
    for (int k = 0; k < n; k++)
      cyc(2'($urandom_range(0, 3)),
          int'($urandom_range(0, 5)), int'($urandom_range(0, MAXV)), int'($urandom_range(0, 1)),
          int'($urandom_range(0, 5)), int'($urandom_range(0, MAXV)), int'($urandom_range(0, 1)));
  endtask

  task automatic check_reset_state();
    chk("rst_we", 32'(phtWE), 32'd0);
    chk("rst_wa", 32'(phtWA), 32'd0);
    chk("rst_wv", 32'(phtWV), 32'd0);
    chk("rst_initDone", 32'(initDone), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_drop", 32'(dropCount), 32'd0);
  endtask

  initial begin
    brValid = '0; brIndex = '0; brPrevValue = '0; brTaken = '0;
    model_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2 check_reset_state();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // INIT sweep with random traffic (all of it must be dropped), then settle.
    rnd(NENT);
    idle(2);

    // Single lane, saturating increment.
    cyc(2'b01, 5, 3, 1, 0, 0, 0);
    idle(2);

    // Two lanes: (1,0) then (2,2) on consecutive cycles.
    cyc(2'b11, 1, 0, 0, 2, 1, 1);
    idle(3);

    // Fill to the top, then push two lanes while popping.
    for (int k = 0; k < 9; k++) cyc(2'b11, (2*k) % 16, 1, 1, (2*k+1) % 16, 2, 0);
    idle(10);

    // Same-index lanes in one cycle.
    cyc(2'b11, 7, 1, 1, 7, 2, 1);
    idle(3);

    // Random traffic.
    rnd(400);

    // Mid-operation reset with queued entries.
    idle(10);
    for (int k = 0; k < 4; k++) cyc(2'b11, 8 + k, 0, 1, 12 + k, 3, 0);
    brValid = '0;
    #2 rst = 1'b0;
    model_reset();
    #1 check_reset_state();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    idle(NENT + 2);
    rnd(200);
    idle(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pht_update_queue.md
# pht_update_queue

Buffers resolved conditional-branch outcomes from the integer issue lanes. Computes each branch's new 2-bit saturating counter value and serialises the writes onto the single write port of the global-history-indexed pattern history table (PHT). It sits between the branch-resolution outputs of the integer pipes and the PHT RAM in the fetch-side predictor. It also owns the post-reset PHT initialisation sweep.

## Interface
- IN_WIDTH, 2, branch-result lanes accepted per cycle (equals INT_ISSUE_WIDTH)
- PHT_INDEX_WIDTH, 10, PHT index width; table has 2^PHT_INDEX_WIDTH entries
- PHT_ENTRY_WIDTH, 2, counter width
- QUEUE_DEPTH, 8, FIFO entries (power of two, ≥ IN_WIDTH)

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- brValid  in  [IN_WIDTH]  lane carries a resolved conditional branch
- brIndex  in  [IN_WIDTH] x PHT_INDEX_WIDTH  global history used at prediction time
- brPrevValue  in  [IN_WIDTH] x PHT_ENTRY_WIDTH  counter value read at prediction time
- brTaken  in  [IN_WIDTH]  executed direction
- phtWE  out  1  PHT write enable
- phtWA  out  PHT_INDEX_WIDTH  PHT write address
- phtWV  out  PHT_ENTRY_WIDTH  PHT write value
- initDone  out  1  initialisation sweep complete
- occupancy  out  log2(QUEUE_DEPTH)+1  current FIFO entry count
- dropCount  out  16  saturating count of discarded results

## Operation
- The block has two states, INIT and RUN.
- Reset (rst=0):
  - State is INIT and the sweep index is 0.
  - FIFO head, tail and occupancy are 0; dropCount is 0.
  - Outputs: phtWE=0, phtWA=0, phtWV=0, initDone=0.
- INIT:
  - Each cycle writes phtWA=sweep index, phtWV=2^(PHT_ENTRY_WIDTH-1) (weakly taken; 2 for 2-bit counters), then increments the index.
  - After writing the last index (all ones), the state moves to RUN and initDone=1 from the next cycle.
  - Valid inputs arriving in INIT are dropped and counted.
- RUN, push:
  - Lanes are processed in order 0..IN_WIDTH-1.
  - New value: brTaken ? min(prev+1, MAX) : max(prev-1, 0), with MAX=2^PHT_ENTRY_WIDTH-1.
  - Each valid lane enqueues {brIndex, new value} if a slot remains, counting slots freed by this cycle's pop.
  - Lanes that find no slot are dropped and counted; lower lanes keep priority.
- RUN, pop:
  - When occupancy>0, the head entry drives phtWE=1, phtWA and phtWV from registers, and is removed.
  - One write per cycle.
- Push and pop occur in the same cycle when possible; head and tail pointers wrap modulo QUEUE_DEPTH.
- dropCount saturates at 0xFFFF.
- Reset asserted mid-operation: discards all queued entries and restarts the INIT sweep from index 0.

## Timing
- A result presented at cycle t is written to the PHT at cycle t+1 at the earliest (queue empty, lane 0); lane 1 of the same cycle is written at t+2.
- phtWE/phtWA/phtWV are registered outputs; there is no combinational path from inputs to them.
- INIT takes exactly 2^PHT_INDEX_WIDTH cycles after reset release.
- With the queue full and a pop in the same cycle, exactly one new lane is accepted.

## Configuration
- PHT_UPDATE_COALESCE_EN defined:
  - An incoming lane whose brIndex equals the index of the most recently enqueued, still-queued entry (the tail entry) overwrites that entry's value instead of allocating a slot.
  - The same applies between lane 1 and lane 0 of the same cycle.
  - A coalesced lane is never counted as dropped.
  - The head entry being popped this cycle is not a coalescing target.
- PHT_UPDATE_COALESCE_EN undefined: every valid lane allocates its own slot.

## Structure
- Shared predictor package holds:
  - PHT_IndexPath / PHT_EntryPath widths
  - PHT_ENTRY_MAX
  - the weakly-taken init constant
  - the queue entry struct {index, value}
- One sub-module, pht_update_fifo: storage plus head/tail/occupancy and multi-push/single-pop logic.
- The counter arithmetic, INIT/RUN state machine and drop counter live in the top.

## Test plan
- Reset, PHT_INDEX_WIDTH=4 → phtWE=1 for 16 cycles with WA=0..15, WV=2; initDone=1 on cycle 17.
- RUN, empty queue, lane0 {idx=5, prev=3, taken=1} → next cycle phtWE=1, WA=5, WV=3 (saturated).
- Both lanes valid {idx=1, prev=0, taken=0} and {idx=2, prev=1, taken=1} → writes (1,0) then (2,2) on consecutive cycles.
- Fill 8 entries, then present two lanes while popping → lane0 accepted, lane1 dropped, dropCount=1, occupancy stays 8.
- With COALESCE_EN, same-cycle lanes both idx=7 (values 2, then 3) → single write (7,3), occupancy never exceeds 1.
- rst asserted with 5 queued entries → outputs zero immediately, queued entries never written, sweep restarts at 0.
